// File: rtl/mem_pkg.sv
// Shared types for the clearable RAM: state encoding of the clear sequencer.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_clr_seq.sv
// Clear sequencer: walks every word address once after reset or on request.
//   state | meaning
//   CLEAR | writing CLEAR_VAL to word cnt, busy asserted
//   READY | memory initialised, user port owns the write path
module mem_clr_seq
  import mem_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        // A request while already clearing is ignored; only READY can restart.
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_ram_clr.sv
// Single-clock WIDTH x DEPTH RAM with a built-in clear sequencer.
// Define MEM_RDREG_EN for a registered (read-first, 1-cycle) read port.
module mem_ram_clr
  import mem_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
  parameter int               AW        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_req,
  output logic             busy,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             user_we;
  logic             rd_in_range;
  logic [WIDTH-1:0] rd_word;

  mem_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clock     (clock),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign user_we = we && !busy && ({1'b0, waddr} < DEPTH_W);

  // Storage has no reset of its own; the clear sequence defines its contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) begin
        mem_q[clr_addr] <= CLEAR_VAL;
      end else if (user_we) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
  assign rd_word     = rd_in_range ? mem_q[raddr] : '0;

`ifdef MEM_RDREG_EN
  logic [WIDTH-1:0] rdata_q, rdata_d;

  assign rdata_d = rd_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  assign rdata = rd_word;
`endif

endmodule

// File: tb/tb_mem_ram_clr.sv
// Bench for mem_ram_clr: a 16-word and a 12-word instance share one stimulus stream
// and are checked every cycle against an array-based reference model.
module tb_mem_ram_clr;

  localparam logic [7:0] CV = 8'hA5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [3:0] raddr = '0;
  logic       busy0, busy1;
  logic [7:0] rdata0, rdata1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: word arrays, words-left-to-clear, registered-read image.
  logic [7:0] mm [2][16];
  int         left [2];
  logic [7:0] rr [2];
  int         dep [2];

  always #5 clock = ~clock;

  mem_ram_clr #(.WIDTH(8), .DEPTH(16), .CLEAR_VAL(CV)) u_dut16 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy0),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata0)
  );

  mem_ram_clr #(.WIDTH(8), .DEPTH(12), .CLEAR_VAL(CV)) u_dut12 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy1),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata1)
  );

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = dep[k];
      rr[k] = (reset || int'(raddr) >= d) ? 8'h00 : mm[k][raddr];
      if (reset) begin
        left[k] = d;
      end else if (left[k] > 0) begin
        mm[k][d - left[k]] = CV;
        left[k] = left[k] - 1;
      end else if (left[k] == 0) begin
        if (clear_req) left[k] = d;
        if (we && int'(waddr) < d) mm[k][waddr] = wdata;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      logic       obs_b;
      logic [7:0] obs_r, exp_r;
      obs_b = (k == 0) ? busy0 : busy1;
      obs_r = (k == 0) ? rdata0 : rdata1;
`ifdef MEM_RDREG_EN
      exp_r = rr[k];
`else
      exp_r = (int'(raddr) < dep[k]) ? mm[k][raddr] : 8'h00;
`endif
      if (left[k] >= 0) begin
        n_assert++;
        assert (obs_b === (left[k] > 0)) else begin
          n_fail++;
          $error("FAIL busy[depth %0d] observed=%0b expected=%0b", dep[k], obs_b, left[k] > 0);
        end
      end
      if (!$isunknown(exp_r)) begin
        n_assert++;
        assert (obs_r === exp_r) else begin
          n_fail++;
          $error("FAIL rdata[depth %0d] raddr=%0d observed=%02h expected=%02h",
                 dep[k], raddr, obs_r, exp_r);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    clear_req = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic read_all();
    we = 1'b0;
    clear_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      raddr = 4'(i);
      cyc();
    end
  endtask

  initial begin
    dep[0] = 16;
    dep[1] = 12;
    for (int k = 0; k < 2; k++) begin
      left[k] = -1;
      rr[k]   = 'x;
      for (int i = 0; i < 16; i++) mm[k][i] = 'x;
    end

    // Reset for one cycle, then clear runs DEPTH cycles; every word reads CLEAR_VAL.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle(18);
    read_all();

    // Write then read back in READY.
    we = 1'b1; waddr = 4'd4; wdata = 8'h3C; raddr = 4'd4;
    cyc();
    we = 1'b0;
    cyc();
    cyc();

    // Writes during a clear are dropped.
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    we = 1'b1; waddr = 4'd2; wdata = 8'hFF;
    repeat (4) cyc();
    idle(14);
    raddr = 4'd2;
    cyc();

    // Reset in the middle of a clear restarts it.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle(7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle(18);

    // Fill with 11, request a clear, and a second request mid-clear is ignored.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; waddr = 4'(i); wdata = 8'h11;
      cyc();
    end
    we = 1'b0;
    read_all();
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    idle(5);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    idle(12);
    read_all();

    // Out-of-range write/read on the 12-word instance.
    we = 1'b1; waddr = 4'd13; wdata = 8'h77; raddr = 4'd13;
    cyc();
    we = 1'b0;
    cyc();

    // Randomised traffic with occasional clear requests and resets.
    for (int n = 0; n < 600; n++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = 4'($urandom_range(0, 15));
      wdata     = 8'($urandom);
      raddr     = 4'($urandom_range(0, 15));
      clear_req = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0;
    idle(20);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
